// File: rtl/nmux_arb_if.sv
// -----------------------------------------------------------------------------
// nmux_arb_if
// Bundles the arbiter's data path, handshake and control signals.
// The clock and reset are plain ports on the arbiter and are not part of this bundle.
//
// Parameters: N channels, W bits per channel, SW select bits, CW counter bits.
//
// Signals:
//   io_in_data   N*W  producer data; channel i sits at [i*W+W-1 : i*W]
//   io_in_valid  N    per-channel valid
//   io_in_ready  N    per-channel ready (driven by the arbiter)
//   io_mode      2    0 manual, 1 fixed priority, 2 round-robin, 3 hold
//   io_sel       SW   channel index used in manual mode
//   io_out_data  W    registered selected word
//   io_out_valid 1    output register holds a word
//   io_out_ready 1    consumer accepts the word
//   io_out_sel   SW   channel that supplied io_out_data
//   io_count     CW   accepted input transfers, wraps
//
// Modports:
//   slave  -- the arbiter's view of the bundle
//   master -- the environment's view: producers, consumer and control
// -----------------------------------------------------------------------------
interface nmux_arb_if #(
    parameter int N  = 5,
    parameter int W  = 8,
    parameter int SW = 3,
    parameter int CW = 16
);
    logic [N*W-1:0] io_in_data;
    logic [N-1:0]   io_in_valid;
    logic [N-1:0]   io_in_ready;
    logic [1:0]     io_mode;
    logic [SW-1:0]  io_sel;
    logic [W-1:0]   io_out_data;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [SW-1:0]  io_out_sel;
    logic [CW-1:0]  io_count;

    modport slave (
        input  io_in_data,
        input  io_in_valid,
        input  io_mode,
        input  io_sel,
        input  io_out_ready,
        output io_in_ready,
        output io_out_data,
        output io_out_valid,
        output io_out_sel,
        output io_count
    );

    modport master (
        output io_in_data,
        output io_in_valid,
        output io_mode,
        output io_sel,
        output io_out_ready,
        input  io_in_ready,
        input  io_out_data,
        input  io_out_valid,
        input  io_out_sel,
        input  io_count
    );
endinterface

// File: rtl/nmux_arb.sv
// -----------------------------------------------------------------------------
// nmux_arb
// N-way arbiter and multiplexer with a single registered output stage.
// Each input channel and the output use a valid/ready handshake.
// The arbiter can sustain one transfer per cycle.
//
// Selection modes:
//   manual         -- the channel named by io_sel
//   fixed priority -- the lowest-index valid channel
//   round-robin    -- the first valid channel at or after the pointer
//   hold           -- no channel is granted
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    nmux_arb_if.slave: data, handshakes, mode/select, count
// -----------------------------------------------------------------------------
module nmux_arb #(
    parameter int N  = 5,
    parameter int W  = 8,
    parameter int SW = 3,
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        reset,
    nmux_arb_if.slave   bus
);

    // Mode encodings
    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_RR     = 2'd2;

    // Output stage, counter and round-robin pointer
    logic [W-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic [CW-1:0] count_q,     count_d;
    logic [SW-1:0] rr_q,        rr_d;

    // Arbitration results
    logic          load_s;
    logic          gnt_any_s;
    logic [SW-1:0] gnt_idx_s;
    logic [N-1:0]  grant_s;
    logic          xfer_s;
    logic [W-1:0]  sel_data_s;
    int            rr_pos_s;
    logic [SW-1:0] rr_idx_s;

    // The output register can take a new word when it is empty
    // or is being drained in this same cycle.
    assign load_s = !out_valid_q || bus.io_out_ready;

    // Pick the winning channel index for the current mode.
    // The loops run from high index to low so that the last match wins.
    // This gives priority to the lowest index, or to the nearest channel after rr.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        rr_pos_s  = 0;
        rr_idx_s  = '0;
        case (bus.io_mode)
            MODE_MANUAL: begin
                // Out-of-range selects (io_sel >= N) grant nothing
                if (int'(bus.io_sel) < N) begin
                    gnt_any_s = bus.io_in_valid[bus.io_sel];
                    gnt_idx_s = bus.io_sel;
                end else begin
                    gnt_any_s = 1'b0;
                    gnt_idx_s = '0;
                end
            end
            MODE_FIXED: begin
                for (int i = N - 1; i >= 0; i--) begin
                    gnt_idx_s = bus.io_in_valid[i] ? SW'(i) : gnt_idx_s;
                    gnt_any_s = gnt_any_s | bus.io_in_valid[i];
                end
            end
            MODE_RR: begin
                for (int k = N - 1; k >= 0; k--) begin
                    // Compute (rr + k) mod N without a divider
                    rr_pos_s  = int'(rr_q) + k;
                    rr_pos_s  = (rr_pos_s >= N) ? (rr_pos_s - N) : rr_pos_s;
                    rr_idx_s  = SW'(rr_pos_s);
                    gnt_idx_s = bus.io_in_valid[rr_idx_s] ? rr_idx_s : gnt_idx_s;
                    gnt_any_s = gnt_any_s | bus.io_in_valid[rr_idx_s];
                end
            end
            default: begin
                gnt_any_s = 1'b0;
                gnt_idx_s = '0;
            end
        endcase
    end

    // Expand the winning index into a one-hot grant vector.
    // In the same loop, select the winning channel's data word.
    always_comb begin
        grant_s    = '0;
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            grant_s[i] = gnt_any_s && (gnt_idx_s == SW'(i));
            sel_data_s = (gnt_idx_s == SW'(i)) ? bus.io_in_data[i*W +: W] : sel_data_s;
        end
    end

    // Ready is held low throughout reset, so no transfer happens in a reset cycle.
    assign bus.io_in_ready = grant_s & {N{load_s && !reset}};
    assign xfer_s          = gnt_any_s && load_s && !reset;

    // Next-state logic for the output register, the counter and the rr pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        count_d     = count_q;
        rr_d        = rr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
            out_sel_d   = gnt_idx_s;
            count_d     = count_q + CW'(1);
            // The pointer only moves on round-robin grants.
            // In other modes it is held, including across mode changes.
            if (bus.io_mode == MODE_RR) begin
                rr_d = (gnt_idx_s == SW'(N - 1)) ? '0 : (gnt_idx_s + SW'(1));
            end else begin
                rr_d = rr_q;
            end
        end else if (out_valid_q && bus.io_out_ready) begin
            // Drained with no replacement: data and sel keep their last values
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            count_q     <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.io_out_data  = out_data_q;
    assign bus.io_out_valid = out_valid_q;
    assign bus.io_out_sel   = out_sel_q;
    assign bus.io_count     = count_q;

endmodule
